dda_stepper: RTL and testbench

//  Parametrised DDA ray stepper for the raycasting pipeline: accepts one ray per handshake from ray-setup,

---
 rtl/dda_pkg.sv | 26 ++
 rtl/dda_div_u.sv | 68 ++++++
 rtl/dda_stepper.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dda_stepper.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dda_pkg.sv
// Shared definitions for the DDA ray stepper: state encoding, fixed-point
// widths and the default column height.
// Optional feature macro: DDA_WALLX_EN (adds the texture-coordinate state).
package dda_pkg;

    localparam int DDA_IBITS         = 8;
    localparam int DDA_FBITS         = 8;
    localparam int DDA_W             = DDA_IBITS + DDA_FBITS;
    localparam int DDA_SCREEN_HEIGHT = 180;

    typedef logic [DDA_W-1:0] fix_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_STEP     = 3'd2,
        S_MAP_WAIT = 3'd3,
        S_HIT      = 3'd4,
        S_DIV_WAIT = 3'd5,
        S_OUT      = 3'd7
`ifdef DDA_WALLX_EN
        , S_WALLX  = 3'd6
`endif
    } dda_state_t;

endpackage

// File: rtl/dda_div_u.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; done pulses once the quotient is final.
module dda_div_u #(
    parameter int W = 16
) (
    input  logic         pixel_clk_in,
    input  logic         rst_n_in,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  div_r;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          ge;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem_r, quo_r[W-1]};
        diff    = shifted - {1'b0, div_r};
        ge      = (shifted >= {1'b0, div_r});
    end

    // Iteration control: W shift/subtract cycles, then a one-cycle done pulse
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(W);
            done <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    // Remainder/quotient shift register; pure datapath, no reset needed
    always_ff @(posedge pixel_clk_in) begin
        if (start) begin
            rem_r <= '0;
            quo_r <= dividend;
            div_r <= divisor;
        end else if (busy) begin
            rem_r <= ge ? diff[W-1:0] : shifted[W-1:0];
            quo_r <= {quo_r[W-2:0], ge};
        end
    end

    assign quotient = quo_r;

endmodule

// File: rtl/dda_stepper.sv
// DDA ray stepper: walks the tile map one grid line at a time for each ray,
// then turns the perpendicular wall distance into a column line height.
// Optional feature macro: DDA_WALLX_EN (texture coordinate via an extra state;
// without it wall_x_out is all ones).
module dda_stepper
    import dda_pkg::*;
#(
    parameter int SCREEN_HEIGHT = DDA_SCREEN_HEIGHT,
    parameter int MAP_W         = 24,
    parameter int MAP_H         = 24,
    parameter int IBITS         = DDA_IBITS,
    parameter int FBITS         = DDA_FBITS,
    parameter int HCOUNT_W      = 9,
    parameter int TILE_W        = 4,
    parameter int MAX_STEPS     = 64,
    parameter logic [TILE_W-1:0] BOUNDARY_TILE = 4'hF,
    localparam int W    = IBITS + FBITS,
    localparam int AW   = $clog2(MAP_W * MAP_H),
    localparam int LH_W = $clog2(SCREEN_HEIGHT + 1)
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    input  logic                 ray_tvalid_in,
    output logic                 ray_tready_out,
    input  logic [HCOUNT_W-1:0]  hcount_ray_in,
    input  logic                 step_x_in,
    input  logic                 step_y_in,
    input  logic signed [W-1:0]  ray_dir_x_in,
    input  logic signed [W-1:0]  ray_dir_y_in,
    input  logic [W-1:0]         delta_dist_x_in,
    input  logic [W-1:0]         delta_dist_y_in,
    input  logic [W-1:0]         pos_x_in,
    input  logic [W-1:0]         pos_y_in,
    input  logic [W-1:0]         side_dist_x_in,
    input  logic [W-1:0]         side_dist_y_in,
    output logic [AW-1:0]        map_addr_out,
    output logic                 map_req_out,
    input  logic [TILE_W-1:0]    map_data_in,
    input  logic                 map_valid_in,
    output logic                 out_tvalid_out,
    input  logic                 out_tready_in,
    output logic [HCOUNT_W-1:0]  hcount_ray_out,
    output logic [LH_W-1:0]      line_height_out,
    output logic                 wall_type_out,
    output logic [TILE_W-1:0]    map_data_out,
    output logic [FBITS-1:0]     wall_x_out,
    output logic                 timeout_out
);

    // Map coordinates carry two extra bits so a step off either edge is visible
    localparam int MC_W  = IBITS + 2;
    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam logic signed [MC_W-1:0] ONE_S   = MC_W'(1);
    localparam logic signed [MC_W-1:0] MAP_W_S = MC_W'(MAP_W);
    localparam logic signed [MC_W-1:0] MAP_H_S = MC_W'(MAP_H);
    localparam logic [W-1:0] DIVIDEND = W'(SCREEN_HEIGHT * (2 ** FBITS));

    dda_state_t              state;
    logic [CNT_W-1:0]        count;
    logic                    step_x_r, step_y_r;
    logic [W-1:0]            delta_x_r, delta_y_r;
    logic [W-1:0]            pos_x_r, pos_y_r;
    logic [W-1:0]            side_x_r, side_y_r;
    logic signed [MC_W-1:0]  map_x_r, map_y_r;

    logic                    x_step;
    logic signed [MC_W-1:0]  nx, ny;
    logic                    oob;
    logic [AW-1:0]           addr_c;
    logic [W-1:0]            perp_c;
    logic                    perp_near;
    logic                    div_start;
    logic                    div_done;
    logic [W-1:0]            div_q;

    // Distance accumulation saturates instead of wrapping
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? '1 : s[W-1:0];
    endfunction

    // Line height never exceeds the column
    function automatic logic [LH_W-1:0] lh_sat(input logic [W-1:0] q);
        if (q > W'(SCREEN_HEIGHT))
            return LH_W'(SCREEN_HEIGHT);
        return q[LH_W-1:0];
    endfunction

    // Next grid cell, bounds test, BRAM address and perpendicular distance
    always_comb begin
        x_step    = (side_x_r < side_y_r);
        nx        = map_x_r;
        ny        = map_y_r;
        if (x_step)
            nx = step_x_r ? map_x_r + ONE_S : map_x_r - ONE_S;
        else
            ny = step_y_r ? map_y_r + ONE_S : map_y_r - ONE_S;
        oob       = (nx < 0) || (nx >= MAP_W_S) || (ny < 0) || (ny >= MAP_H_S);
        addr_c    = AW'(32'(nx) + 32'(ny) * MAP_W);
        perp_c    = wall_type_out ? (side_y_r - delta_y_r) : (side_x_r - delta_x_r);
        perp_near = (perp_c[W-1:FBITS] == '0);
        div_start = (state == S_HIT) && !perp_near;
    end

    dda_div_u #(.W(W)) u_div (
        .pixel_clk_in (pixel_clk_in),
        .rst_n_in     (rst_n_in),
        .start        (div_start),
        .dividend     (DIVIDEND),
        .divisor      (perp_c),
        .done         (div_done),
        .quotient     (div_q)
    );

`ifdef DDA_WALLX_EN
    localparam int PW = 2 * W + 1;
    logic signed [W-1:0]  ray_dir_x_r, ray_dir_y_r;
    logic [W-1:0]         perp_r;
    logic [W-1:0]         wx_pos;
    logic signed [W-1:0]  wx_dir;
    logic signed [PW-1:0] wx_prod, wx_sum;

    // Wall hit coordinate along the wall: pos + perp * ray_dir on the other axis
    always_comb begin
        wx_pos  = wall_type_out ? pos_x_r : pos_y_r;
        wx_dir  = wall_type_out ? ray_dir_x_r : ray_dir_y_r;
        wx_prod = PW'($signed({1'b0, perp_r})) * PW'(wx_dir);
        wx_sum  = (wx_prod >>> FBITS) + $signed(PW'(wx_pos));
    end

    // Ray direction and distance kept only for the texture coordinate
    always_ff @(posedge pixel_clk_in) begin
        if (state == S_IDLE && ray_tvalid_in) begin
            ray_dir_x_r <= ray_dir_x_in;
            ray_dir_y_r <= ray_dir_y_in;
        end
        if (state == S_HIT)
            perp_r <= perp_c;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{ray_dir_x_in, ray_dir_y_in, pos_x_r[FBITS-1:0], pos_y_r[FBITS-1:0]};
`endif

    assign ray_tready_out = (state == S_IDLE);

    // Ray datapath: latch the ray, then advance side distances and map cell
    always_ff @(posedge pixel_clk_in) begin
        case (state)
            S_IDLE: if (ray_tvalid_in) begin
                step_x_r  <= step_x_in;
                step_y_r  <= step_y_in;
                delta_x_r <= delta_dist_x_in;
                delta_y_r <= delta_dist_y_in;
                pos_x_r   <= pos_x_in;
                pos_y_r   <= pos_y_in;
                side_x_r  <= side_dist_x_in;
                side_y_r  <= side_dist_y_in;
            end
            S_INIT: begin
                map_x_r <= $signed({2'b00, pos_x_r[W-1:FBITS]});
                map_y_r <= $signed({2'b00, pos_y_r[W-1:FBITS]});
            end
            S_STEP: begin
                if (x_step)
                    side_x_r <= sat_add(side_x_r, delta_x_r);
                else
                    side_y_r <= sat_add(side_y_r, delta_y_r);
                map_x_r <= nx;
                map_y_r <= ny;
            end
            default: ;
        endcase
    end

    // Sequencer and registered result outputs
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= S_IDLE;
            count           <= '0;
            map_addr_out    <= '0;
            map_req_out     <= 1'b0;
            out_tvalid_out  <= 1'b0;
            hcount_ray_out  <= '0;
            line_height_out <= '0;
            wall_type_out   <= 1'b0;
            map_data_out    <= '0;
            wall_x_out      <= '0;
            timeout_out     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ray_tvalid_in) begin
                    hcount_ray_out <= hcount_ray_in;
                    state          <= S_INIT;
                end
                S_INIT: begin
                    count       <= '0;
                    timeout_out <= 1'b0;
`ifdef DDA_WALLX_EN
                    wall_x_out  <= '0;
`else
                    wall_x_out  <= '1;
`endif
                    state       <= S_STEP;
                end
                S_STEP: begin
                    wall_type_out <= !x_step;
                    if (oob) begin
                        map_data_out <= BOUNDARY_TILE;
                        state        <= S_HIT;
                    end else begin
                        map_addr_out <= addr_c;
                        map_req_out  <= 1'b1;
                        state        <= S_MAP_WAIT;
                    end
                end
                S_MAP_WAIT: if (map_valid_in) begin
                    map_req_out  <= 1'b0;
                    map_data_out <= map_data_in;
                    if (map_data_in != '0) begin
                        state <= S_HIT;
                    end else if (count == CNT_W'(MAX_STEPS - 1)) begin
                        timeout_out     <= 1'b1;
                        line_height_out <= '0;
                        map_data_out    <= '0;
                        out_tvalid_out  <= 1'b1;
                        state           <= S_OUT;
                    end else begin
                        count <= count + CNT_W'(1);
                        state <= S_STEP;
                    end
                end
                S_HIT: begin
                    if (perp_near) begin
                        line_height_out <= LH_W'(SCREEN_HEIGHT);
`ifdef DDA_WALLX_EN
                        state           <= S_WALLX;
`else
                        out_tvalid_out  <= 1'b1;
                        state           <= S_OUT;
`endif
                    end else begin
                        state <= S_DIV_WAIT;
                    end
                end
                S_DIV_WAIT: if (div_done) begin
                    line_height_out <= lh_sat(div_q);
`ifdef DDA_WALLX_EN
                    state           <= S_WALLX;
`else
                    out_tvalid_out  <= 1'b1;
                    state           <= S_OUT;
`endif
                end
`ifdef DDA_WALLX_EN
                S_WALLX: begin
                    wall_x_out     <= wx_sum[FBITS-1:0];
                    out_tvalid_out <= 1'b1;
                    state          <= S_OUT;
                end
`endif
                S_OUT: if (out_tready_in) begin
                    out_tvalid_out <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dda_stepper.sv
// Testbench for dda_stepper: directed rays plus randomized rays and maps,
// each compared against a transaction-level DDA walk computed in the bench.
module tb_dda_stepper;

    localparam int W     = 16;
    localparam int MAP_W = 24;
    localparam int MAP_H = 64;
    localparam int MSZ   = MAP_W * MAP_H;
    localparam int AW    = $clog2(MSZ);
    localparam int LH_W  = $clog2(181);
    localparam int HC_W  = 9;
    localparam int TW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              ray_tvalid_in, ray_tready_out;
    logic [HC_W-1:0]   r_hc;
    logic              r_stx, r_sty;
    logic signed [W-1:0] r_dirx, r_diry;
    logic [W-1:0]      r_dx, r_dy, r_px, r_py, r_sx, r_sy;
    logic [AW-1:0]     map_addr_out;
    logic              map_req_out;
    logic [TW-1:0]     map_data_in;
    logic              map_valid_in;
    logic              out_tvalid_out, out_tready_in;
    logic [HC_W-1:0]   hcount_ray_out;
    logic [LH_W-1:0]   line_height_out;
    logic              wall_type_out;
    logic [TW-1:0]     map_data_out;
    logic [7:0]        wall_x_out;
    logic              timeout_out;

    dda_stepper #(.MAP_H(MAP_H)) dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .ray_tvalid_in   (ray_tvalid_in),
        .ray_tready_out  (ray_tready_out),
        .hcount_ray_in   (r_hc),
        .step_x_in       (r_stx),
        .step_y_in       (r_sty),
        .ray_dir_x_in    (r_dirx),
        .ray_dir_y_in    (r_diry),
        .delta_dist_x_in (r_dx),
        .delta_dist_y_in (r_dy),
        .pos_x_in        (r_px),
        .pos_y_in        (r_py),
        .side_dist_x_in  (r_sx),
        .side_dist_y_in  (r_sy),
        .map_addr_out    (map_addr_out),
        .map_req_out     (map_req_out),
        .map_data_in     (map_data_in),
        .map_valid_in    (map_valid_in),
        .out_tvalid_out  (out_tvalid_out),
        .out_tready_in   (out_tready_in),
        .hcount_ray_out  (hcount_ray_out),
        .line_height_out (line_height_out),
        .wall_type_out   (wall_type_out),
        .map_data_out    (map_data_out),
        .wall_x_out      (wall_x_out),
        .timeout_out     (timeout_out)
    );

    typedef struct {
        int hc; int lh; int wt; int tile; int to; int wx; int reads;
    } exp_t;

    logic [TW-1:0] mem [MSZ];
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   reads_seen = 0;
    int   last_addr = -1;
    int   wait_cnt = 0;
    bit   mem_en = 1'b1;
    bit   bp_en = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: walk the grid with plain integers following the DDA rules
    task automatic model(output exp_t e);
        int sx, sy, mx, my, reads, perp, tile, side;
        bit to;
        sx = r_sx; sy = r_sy; mx = int'(r_px >> 8); my = int'(r_py >> 8);
        reads = 0; to = 0; tile = 0; side = 0;
        forever begin
            if (sx < sy) begin
                sx = sx + int'(r_dx); if (sx > 65535) sx = 65535;
                mx = r_stx ? mx + 1 : mx - 1; side = 0;
            end else begin
                sy = sy + int'(r_dy); if (sy > 65535) sy = 65535;
                my = r_sty ? my + 1 : my - 1; side = 1;
            end
            if (mx < 0 || mx >= MAP_W || my < 0 || my >= MAP_H) begin
                tile = 15; break;
            end
            reads++;
            tile = int'(mem[mx + my * MAP_W]);
            if (tile != 0) break;
            if (reads == 64) begin to = 1; break; end
        end
        e.hc = int'(r_hc); e.wt = side; e.reads = reads; e.to = int'(to);
        e.wx = 255;
        if (to) begin
            e.lh = 0; e.tile = 0;
`ifdef DDA_WALLX_EN
            e.wx = 0;
`endif
        end else begin
            e.tile = tile;
            perp = side ? sy - int'(r_dy) : sx - int'(r_dx);
            if (perp < 256) e.lh = 180;
            else begin
                e.lh = (180 * 256) / perp;
                if (e.lh > 180) e.lh = 180;
            end
`ifdef DDA_WALLX_EN
            begin
                longint p;
                p = longint'(perp) * (side ? longint'(r_dirx) : longint'(r_diry));
                e.wx = int'(((side ? longint'(r_px) : longint'(r_py)) + (p >>> 8)) & 255);
            end
`endif
        end
    endtask

    task automatic send_ray(output exp_t e);
        model(e);
        exp_q.push_back(e);
        reads_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (ray_tready_out) break;
            @(posedge clk); #1;
        end
        check("ray_ready", int'(ray_tready_out), 1);
        ray_tvalid_in = 1'b1;
        @(posedge clk); #1;
        ray_tvalid_in = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
            if (bp_en) out_tready_in = (($urandom % 3) != 0);
        end
        check("result_pending", exp_q.size(), 0);
        exp_q.delete();
        out_tready_in = 1'b1;
    endtask

    task automatic base_ray();
        r_hc = 9'd17; r_stx = 1'b1; r_sty = 1'b1;
        r_dirx = 16'sh0100; r_diry = 16'sh0080;
        r_dx = 16'h0100; r_dy = 16'h0100;
        r_px = 16'h0280; r_py = 16'h0280;
        r_sx = 16'h0080; r_sy = 16'h0100;
    endtask

    task automatic clear_map();
        for (int i = 0; i < MSZ; i++) mem[i] = '0;
    endtask

    // BRAM stand-in: answers a held request after 1-3 cycles with a single-cycle strobe
    initial begin
        map_valid_in = 1'b0;
        map_data_in  = '0;
        forever begin
            @(posedge clk); #1;
            if (map_valid_in) begin
                map_valid_in = 1'b0;
            end else if (mem_en && rst_n && map_req_out) begin
                if (wait_cnt == 0) begin
                    check("addr_in_map", int'(int'(map_addr_out) < MSZ), 1);
                    map_data_in  = (int'(map_addr_out) < MSZ) ? mem[map_addr_out] : '0;
                    map_valid_in = 1'b1;
                    reads_seen++;
                    last_addr = int'(map_addr_out);
                    wait_cnt = $urandom_range(0, 2);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Per-cycle compare: handshake results against the model, hold stability, ready/valid exclusion
    bit prev_pend = 1'b0;
    int prev_fields = 0;
    always @(negedge clk) begin
        int cur;
        exp_t e;
        if (rst_n) begin
            cur = int'({hcount_ray_out, line_height_out, wall_type_out, map_data_out,
                        wall_x_out, timeout_out});
            check("rdy_vld_excl", int'(ray_tready_out && out_tvalid_out), 0);
            if (prev_pend && out_tvalid_out) check("hold_stable", cur, prev_fields);
            if (prev_pend) check("hold_valid", int'(out_tvalid_out), 1);
            if (out_tvalid_out && out_tready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("hcount", int'(hcount_ray_out), e.hc);
                    check("line_height", int'(line_height_out), e.lh);
                    check("wall_type", int'(wall_type_out), e.wt);
                    check("tile", int'(map_data_out), e.tile);
                    check("timeout", int'(timeout_out), e.to);
                    check("wall_x", int'(wall_x_out), e.wx);
                    check("map_reads", reads_seen, e.reads);
                end
            end
            prev_pend   = out_tvalid_out && !out_tready_in;
            prev_fields = cur;
        end else begin
            prev_pend = 1'b0;
        end
    end

    initial begin
        exp_t e;
        int snap;
        ray_tvalid_in = 1'b0;
        out_tready_in = 1'b1;
        base_ray();
        clear_map();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ray_tready_out), 1);
        check("rst_req", int'(map_req_out), 0);
        check("rst_valid", int'(out_tvalid_out), 0);
        check("rst_addr", int'(map_addr_out), 0);
        check("rst_lh", int'(line_height_out), 0);
        check("rst_wallx", int'(wall_x_out), 0);
        check("rst_timeout", int'(timeout_out), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Near wall on X side: one read at address 51
        mem[3 + 2 * MAP_W] = 4'd5;
        send_ray(e);
        wait_result();
        check("t1_addr", last_addr, 51);
        check("t1_m_reads", e.reads, 1);
        check("t1_m_lh", e.lh, 180);
        check("t1_m_wt", e.wt, 0);
        check("t1_m_tile", e.tile, 5);

        // Distance 3.0 -> line height 60
        mem[3 + 2 * MAP_W] = 4'd2;
        r_sx = 16'h0300; r_sy = 16'h0800;
        send_ray(e);
        wait_result();
        check("t2_m_lh", e.lh, 60);
        check("t2_m_to", e.to, 0);
        check("t2_m_tile", e.tile, 2);

        // Leaves the map on the right edge: boundary tile, no read
        base_ray();
        r_px = 16'h1780;
        send_ray(e);
        wait_result();
        check("t3_reads", reads_seen, 0);
        check("t3_m_tile", e.tile, 15);
        check("t3_m_wt", e.wt, 0);

        // Empty map: forced termination after the read budget
        clear_map();
        base_ray();
        r_px = 16'h0080; r_py = 16'h0080; r_sx = 16'h0080; r_sy = 16'h0080;
        r_dx = 16'h0100; r_dy = 16'h0080;
        send_ray(e);
        wait_result();
        check("t4_m_reads", e.reads, 64);
        check("t4_m_to", e.to, 1);
        check("t4_m_lh", e.lh, 0);

        // Texture coordinate: pos_y 2.25, dir_y 0.5, perp 1.0 on X side
        base_ray();
        mem[3 + 2 * MAP_W] = 4'd7;
        r_py = 16'h0240; r_sx = 16'h0100; r_sy = 16'h0800;
        send_ray(e);
        wait_result();
`ifdef DDA_WALLX_EN
        check("t6_m_wx", e.wx, 8'hC0);
`else
        check("t6_m_wx", e.wx, 8'hFF);
`endif
        check("t6_m_lh", e.lh, 180);

        // Downstream stall: result held, no new ray taken
        base_ray();
        mem[3 + 2 * MAP_W] = 4'd5;
        out_tready_in = 1'b0;
        send_ray(e);
        for (int i = 0; i < 500; i++) begin
            if (out_tvalid_out) break;
            @(posedge clk); #1;
        end
        check("bp_valid_seen", int'(out_tvalid_out), 1);
        snap = int'({hcount_ray_out, line_height_out, map_data_out});
        ray_tvalid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", int'(out_tvalid_out), 1);
            check("bp_no_ready", int'(ray_tready_out), 0);
            check("bp_fields", int'({hcount_ray_out, line_height_out, map_data_out}), snap);
        end
        ray_tvalid_in = 1'b0;
        out_tready_in = 1'b1;
        wait_result();

        // Reset while waiting on the map read
        mem_en = 1'b0;
        send_ray(e);
        for (int i = 0; i < 50; i++) begin
            if (map_req_out) break;
            @(posedge clk); #1;
        end
        check("rst_req_seen", int'(map_req_out), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", int'(map_req_out), 0);
        check("mid_rst_valid", int'(out_tvalid_out), 0);
        check("mid_rst_ready", int'(ray_tready_out), 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_valid", int'(out_tvalid_out), 0);
        check("post_rst_req", int'(map_req_out), 0);
        check("post_rst_ready", int'(ray_tready_out), 1);

        // Random rays over random maps with random downstream stalls
        bp_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < MSZ; i++)
                mem[i] = (($urandom % 5) == 0) ? TW'($urandom_range(1, 15)) : '0;
            r_hc   = HC_W'($urandom);
            r_stx  = 1'($urandom);
            r_sty  = 1'($urandom);
            r_dirx = W'($urandom);
            r_diry = W'($urandom);
            r_dx   = (($urandom % 8) == 0) ? W'($urandom_range(16'hF000, 16'hFFFF)) : W'($urandom_range(64, 1536));
            r_dy   = (($urandom % 8) == 0) ? W'($urandom_range(16'hF000, 16'hFFFF)) : W'($urandom_range(64, 1536));
            r_px   = {8'($urandom_range(0, MAP_W - 1)), 8'($urandom)};
            r_py   = {8'($urandom_range(0, MAP_H - 1)), 8'($urandom)};
            r_sx   = W'($urandom_range(0, 2048));
            r_sy   = W'($urandom_range(0, 2048));
            send_ray(e);
            wait_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
